// File: rtl/mbox_link_fifo.sv
// Buffered single-clock link between a mailbox writer port and a peer reader port:
// FWFT word FIFO, packet delimiting with done, and two-sided abort arbitration with timeout.
module mbox_link_fifo #(
    parameter int DW       = 32,
    parameter int DEPTH    = 8,
    parameter int ABORT_TO = 1024
) (
    input  logic                     aclk,
    input  logic                     resetn,
    input  logic [DW-1:0]            wr_dat,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic                     wr_done,
    input  logic                     wr_abort_i,
    output logic                     wr_abort_o,
    output logic [DW-1:0]            rd_dat,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic                     rd_done,
    input  logic                     rd_abort_i,
    output logic                     rd_abort_o,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(ABORT_TO);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DONE_WAIT = 2'd1,
        ABORT_W   = 2'd2,
        ABORT_R   = 2'd3
    } state_t;

    state_t          state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   count;
    logic [TW-1:0]   timer;
    logic [DW-1:0]   mem [DEPTH];

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic timeout;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign timeout = (timer == TW'(ABORT_TO - 1));

    // Gated by resetn so the writer sees no acceptance while the link is held in reset.
    assign wr_ready = resetn && !full && (state == IDLE);
    assign rd_valid = !empty && ((state == IDLE) || (state == DONE_WAIT));
    assign rd_dat   = rd_valid ? mem[rd_ptr] : '0;
    assign level    = count;

    assign push = wr_valid && wr_ready;
    assign pop  = rd_valid && rd_ready;

    // NOTE: the storage array has no reset; stale contents are never visible because
    // rd_dat is masked whenever rd_valid is low.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            timer      <= '0;
            rd_done    <= 1'b0;
            wr_abort_o <= 1'b0;
            rd_abort_o <= 1'b0;
            err        <= 1'b0;
        end else begin
            rd_done    <= 1'b0;
            wr_abort_o <= 1'b0;
            rd_abort_o <= 1'b0;
            err        <= 1'b0;

            case (state)
                IDLE, DONE_WAIT: begin
                    if (wr_abort_i || rd_abort_i) begin
                        // Any abort flushes; simultaneous requests acknowledge each other.
                        count  <= '0;
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        timer  <= '0;
                        if (wr_abort_i && rd_abort_i) begin
                            state <= IDLE;
                        end else if (wr_abort_i) begin
                            rd_abort_o <= 1'b1;
                            state      <= ABORT_W;
                        end else begin
                            wr_abort_o <= 1'b1;
                            state      <= ABORT_R;
                        end
                    end else begin
                        if (push) begin
                            wr_ptr <= wr_ptr + AW'(1);
                        end
                        if (pop) begin
                            rd_ptr <= rd_ptr + AW'(1);
                        end
                        count <= count + LW'(push) - LW'(pop);
                        if (state == IDLE) begin
                            if (wr_done) begin
                                state <= DONE_WAIT;
                            end
                        end else if (empty) begin
                            rd_done <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end

                ABORT_W: begin
                    if (rd_abort_i || timeout) begin
                        wr_abort_o <= 1'b1;
                        err        <= !rd_abort_i;
                        timer      <= '0;
                        state      <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                ABORT_R: begin
                    if (wr_abort_i || timeout) begin
                        rd_abort_o <= 1'b1;
                        err        <= !wr_abort_i;
                        timer      <= '0;
                        state      <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mbox_link_fifo.sv
// Directed self-checking bench for mbox_link_fifo: FIFO flow, full boundary, packet done,
// abort handshakes, abort timeout and reset mid-packet.
module tb_mbox_link_fifo;

    localparam int DW = 32;

    logic          aclk = 1'b0;
    logic          resetn;
    logic [DW-1:0] wr_dat;
    logic          wr_valid;
    logic          wr_ready;
    logic          wr_done;
    logic          wr_abort_i;
    logic          wr_abort_o;
    logic [DW-1:0] rd_dat;
    logic          rd_valid;
    logic          rd_ready;
    logic          rd_done;
    logic          rd_abort_i;
    logic          rd_abort_o;
    logic [3:0]    level;
    logic          err;

    int n_checks = 0;
    int n_pass   = 0;

    mbox_link_fifo #(.DW(DW), .DEPTH(8), .ABORT_TO(1024)) dut (
        .aclk       (aclk),
        .resetn     (resetn),
        .wr_dat     (wr_dat),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_done    (wr_done),
        .wr_abort_i (wr_abort_i),
        .wr_abort_o (wr_abort_o),
        .rd_dat     (rd_dat),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_done    (rd_done),
        .rd_abort_i (rd_abort_i),
        .rd_abort_o (rd_abort_o),
        .level      (level),
        .err        (err)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d, input logic done);
        wr_dat   = d;
        wr_valid = 1'b1;
        wr_done  = done;
        tick();
        wr_valid = 1'b0;
        wr_done  = 1'b0;
    endtask

    logic [31:0] abc [3];
    int          n;

    initial begin
        abc[0] = 32'hA;
        abc[1] = 32'hB;
        abc[2] = 32'hC;

        resetn = 1'b0; wr_dat = '0; wr_valid = 1'b0; wr_done = 1'b0; wr_abort_i = 1'b0;
        rd_ready = 1'b0; rd_abort_i = 1'b0;
        tick();
        tick();
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_pulses", {28'd0, rd_done, wr_abort_o, rd_abort_o, err}, 32'd0);
        check("rst_rd_dat", rd_dat, 32'd0);
        resetn = 1'b1;
        #1;
        check("post_rst_wr_ready", 32'(wr_ready), 32'd1);

        // 1: three words with reader stalled, then drained back to back
        push_word(abc[0], 1'b0);
        check("t1_fwft_valid", 32'(rd_valid), 32'd1);
        push_word(abc[1], 1'b0);
        push_word(abc[2], 1'b0);
        check("t1_level3", 32'(level), 32'd3);
        check("t1_head", rd_dat, 32'hA);
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t1_valid", 32'(rd_valid), 32'd1);
            check("t1_dat", rd_dat, abc[i]);
            tick();
        end
        rd_ready = 1'b0;
        check("t1_level0", 32'(level), 32'd0);
        check("t1_empty", 32'(rd_valid), 32'd0);

        // 2: fill to full, simultaneous pop+push at full must refuse the push
        for (int i = 0; i < 8; i++) begin
            check("t2_ready_fill", 32'(wr_ready), 32'd1);
            push_word(32'h100 + 32'(i), 1'b0);
        end
        check("t2_level8", 32'(level), 32'd8);
        check("t2_full_ready", 32'(wr_ready), 32'd0);
        wr_dat = 32'hDEAD; wr_valid = 1'b1; rd_ready = 1'b1;
        tick();
        wr_valid = 1'b0; rd_ready = 1'b0;
        check("t2_level7", 32'(level), 32'd7);
        check("t2_ready_after_pop", 32'(wr_ready), 32'd1);
        rd_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            check("t2_drain", rd_dat, 32'h100 + 32'(i));
            tick();
        end
        rd_ready = 1'b0;
        check("t2_drained", 32'(level), 32'd0);

        // 3: two-word packet delimited by wr_done on the last word
        push_word(32'h31, 1'b0);
        push_word(32'h32, 1'b1);
        check("t3_done_wait_ready", 32'(wr_ready), 32'd0);
        check("t3_level2", 32'(level), 32'd2);
        wr_done = 1'b1;  // ignored while already waiting
        rd_ready = 1'b1;
        check("t3_w0", rd_dat, 32'h31);
        tick();
        wr_done = 1'b0;
        check("t3_w1", rd_dat, 32'h32);
        tick();
        rd_ready = 1'b0;
        check("t3_no_early_done", 32'(rd_done), 32'd0);
        tick();
        check("t3_done_pulse", 32'(rd_done), 32'd1);
        check("t3_idle_ready", 32'(wr_ready), 32'd1);
        tick();
        check("t3_done_single", 32'(rd_done), 32'd0);

        // 4: writer abort at level 5, reader acks 10 cycles later
        for (int i = 0; i < 5; i++) push_word(32'h40 + 32'(i), 1'b0);
        check("t4_level5", 32'(level), 32'd5);
        wr_abort_i = 1'b1;
        tick();
        wr_abort_i = 1'b0;
        check("t4_flush", 32'(level), 32'd0);
        check("t4_rd_abort_o", 32'(rd_abort_o), 32'd1);
        check("t4_blocked", {30'd0, wr_ready, rd_valid}, 32'd0);
        tick();
        check("t4_rd_abort_o_1cyc", 32'(rd_abort_o), 32'd0);
        wr_abort_i = 1'b1;  // repeat request is ignored
        tick();
        wr_abort_i = 1'b0;
        tick();
        check("t4_repeat_ignored", {30'd0, rd_abort_o, wr_abort_o}, 32'd0);
        for (int i = 0; i < 6; i++) tick();
        rd_abort_i = 1'b1;
        tick();
        rd_abort_i = 1'b0;
        check("t4_wr_abort_o", 32'(wr_abort_o), 32'd1);
        check("t4_no_err", 32'(err), 32'd0);
        tick();
        check("t4_wr_abort_o_1cyc", 32'(wr_abort_o), 32'd0);
        check("t4_back_idle", 32'(wr_ready), 32'd1);

        // 5: reader abort never acked by writer -> forced completion with err
        rd_abort_i = 1'b1;
        tick();
        rd_abort_i = 1'b0;
        check("t5_wr_abort_o", 32'(wr_abort_o), 32'd1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!err && n < 1100);
        check("t5_timeout_cycles", 32'(n), 32'd1024);
        check("t5_rd_abort_o", 32'(rd_abort_o), 32'd1);
        check("t5_err", 32'(err), 32'd1);
        tick();
        check("t5_err_1cyc", {30'd0, err, rd_abort_o}, 32'd0);
        check("t5_idle", 32'(wr_ready), 32'd1);

        // 6a: simultaneous aborts acknowledge each other silently
        push_word(32'h61, 1'b0);
        push_word(32'h62, 1'b0);
        wr_abort_i = 1'b1; rd_abort_i = 1'b1;
        tick();
        wr_abort_i = 1'b0; rd_abort_i = 1'b0;
        check("t6_flush", 32'(level), 32'd0);
        check("t6_no_pulses", {29'd0, wr_abort_o, rd_abort_o, err}, 32'd0);
        check("t6_idle", 32'(wr_ready), 32'd1);
        tick();
        check("t6_no_pulses_later", {29'd0, wr_abort_o, rd_abort_o, err}, 32'd0);

        // 6b: reset while waiting for the reader to drain a packet
        push_word(32'h63, 1'b1);
        check("t6_in_done_wait", 32'(wr_ready), 32'd0);
        resetn = 1'b0; rd_ready = 1'b1;
        tick();
        check("t6_rst_outs", {28'd0, wr_ready, rd_valid, rd_done, err}, 32'd0);
        check("t6_rst_level", 32'(level), 32'd0);
        check("t6_rst_dat", rd_dat, 32'd0);
        resetn = 1'b1; rd_ready = 1'b0;
        tick();
        check("t6_no_done_a", 32'(rd_done), 32'd0);
        tick();
        check("t6_no_done_b", 32'(rd_done), 32'd0);
        check("t6_ready_again", 32'(wr_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
